// File: rtl/probe_scheduler.sv
// probe_scheduler: sweeps the masked AXIS channels through a probe core, one capture at a time.
// Build option PROBE_SCHED_STATS_EN: beat_cnt reports the final beat count of the last finished channel.

module probe_scheduler #(
  parameter int NUM     = 8,
  parameter int TIMEOUT = 1000,
  parameter int GAP     = 4
) (
  input  logic        ap_clk,
  input  logic        ap_rst,
  input  logic        start,
  input  logic        abort,
  input  logic [7:0]  chan_mask,
  input  logic [16:0] size_cfg,
  input  logic        probe_tvalid,
  input  logic        probe_tready,
  input  logic        probe_tlast,
  output logic        en,
  output logic [2:0]  sel,
  output logic [16:0] size,
  output logic        busy,
  output logic        done,
  output logic [7:0]  chan_done,
  output logic [7:0]  chan_tmo,
  output logic [16:0] beat_cnt
);

  // state      | meaning
  // ST_IDLE    | waiting for start
  // ST_ARM     | one cycle with sel settled and en low
  // ST_CAPTURE | en high, counting beats and idle cycles
  // ST_GAP     | en low spacing before the next channel
  // ST_FIN     | done pulse, then back to idle

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);
  localparam logic [7:0]    NUM_MASK  = 8'((9'd1 << NUM) - 9'd1);
  localparam logic [16:0]   BEAT_MAX  = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_CAPTURE,
    ST_GAP,
    ST_FIN
  } state_t;

  state_t        state_q, state_d;
  logic [7:0]    mask_q;
  logic [7:0]    start_mask;
  logic [2:0]    first_sel, next_sel;
  logic          first_any, next_any;
  logic [16:0]   beat_q, beat_nxt;
  logic [IW-1:0] idle_q;
  logic [GW-1:0] gap_q;
  logic          beat, cap_done, cap_tmo, cap_end;

  assign beat       = probe_tvalid & probe_tready;
  assign beat_nxt   = (beat_q == BEAT_MAX) ? beat_q : beat_q + 17'd1;
  assign cap_done   = beat && (probe_tlast || ((size != '0) && (beat_nxt == size)));
  // a beat on the would-be timeout cycle wins, hence the !beat term
  assign cap_tmo    = !beat && (idle_q == IDLE_LAST);
  assign cap_end    = (state_q == ST_CAPTURE) && !abort && (cap_done || cap_tmo);
  assign start_mask = chan_mask & NUM_MASK;

  assign en   = (state_q == ST_CAPTURE);
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FIN);

  // descending scan leaves the lowest qualifying bit
  always_comb begin
    first_sel = '0;
    first_any = 1'b0;
    next_sel  = '0;
    next_any  = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      if (start_mask[i]) begin
        first_sel = 3'(i);
        first_any = 1'b1;
      end
      if (mask_q[i] && (i > int'(sel))) begin
        next_sel = 3'(i);
        next_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = first_any ? ST_ARM : ST_FIN;
      ST_ARM:     state_d = ST_CAPTURE;
      ST_CAPTURE: if (cap_done || cap_tmo) state_d = ST_GAP;
      ST_GAP:     if (gap_q == '0) state_d = next_any ? ST_ARM : ST_FIN;
      ST_FIN:     state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) state_d = ST_IDLE;
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q   <= ST_IDLE;
      mask_q    <= '0;
      sel       <= '0;
      size      <= '0;
      chan_done <= '0;
      chan_tmo  <= '0;
      beat_q    <= '0;
      idle_q    <= '0;
      gap_q     <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            mask_q    <= start_mask;
            size      <= size_cfg;
            sel       <= first_sel;
            chan_done <= '0;
            chan_tmo  <= '0;
          end
        end
        ST_ARM: begin
          beat_q <= '0;
          idle_q <= '0;
        end
        ST_CAPTURE: begin
          if (beat) begin
            beat_q <= beat_nxt;
            idle_q <= '0;
          end else begin
            idle_q <= idle_q + 1'b1;
          end
          if (cap_end) begin
            gap_q <= GAP_LAST;
            if (cap_done) chan_done[sel] <= 1'b1;
            else          chan_tmo[sel]  <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_q != '0)         gap_q <= gap_q - 1'b1;
          else if (state_d == ST_ARM) sel <= next_sel;
        end
        default: ;
      endcase
    end
  end

`ifdef PROBE_SCHED_STATS_EN
  logic [16:0] last_q;

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst)       last_q <= '0;
    else if (cap_end) last_q <= beat ? beat_nxt : beat_q;
  end

  assign beat_cnt = last_q;
`else
  assign beat_cnt = '0;
`endif

endmodule

// File: tb/tb_probe_scheduler.sv
// tb_probe_scheduler: directed and randomized sweeps of probe_scheduler against a per-channel plan model.
// Honours PROBE_SCHED_STATS_EN for the expected beat_cnt value.

module tb_probe_scheduler;

  localparam int NUM     = 8;
  localparam int TIMEOUT = 1000;
  localparam int GAP     = 4;
`ifdef PROBE_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        ap_clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  chan_mask = '0;
  logic [16:0] size_cfg = '0;
  logic        probe_tvalid = 1'b0;
  logic        probe_tready = 1'b0;
  logic        probe_tlast = 1'b0;
  logic        en, busy, done;
  logic [2:0]  sel;
  logic [16:0] size, beat_cnt;
  logic [7:0]  chan_done, chan_tmo;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic v;
    logic r;
    logic l;
  } drv_t;

  drv_t plan[$];

  always #5 ap_clk = ~ap_clk;

  probe_scheduler #(.NUM(NUM), .TIMEOUT(TIMEOUT), .GAP(GAP)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .abort(abort),
    .chan_mask(chan_mask), .size_cfg(size_cfg),
    .probe_tvalid(probe_tvalid), .probe_tready(probe_tready), .probe_tlast(probe_tlast),
    .en(en), .sel(sel), .size(size), .busy(busy), .done(done),
    .chan_done(chan_done), .chan_tmo(chan_tmo), .beat_cnt(beat_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_drive();
    probe_tvalid = 1'b0;
    probe_tready = 1'($urandom_range(0, 1));
    probe_tlast  = 1'($urandom_range(0, 1));
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_en"}, en, 0);
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_size"}, size, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_chan_done"}, chan_done, 0);
    chk({tag, "_chan_tmo"}, chan_tmo, 0);
    chk({tag, "_beat_cnt"}, beat_cnt, 0);
  endtask

  // Channel model: idle runs of TIMEOUT cycles time out; a tlast beat or the size-th beat completes.
  task automatic build_plan(input int nbeats, input bit tmo, input logic [16:0] sz, input int pre_idle,
                            input bit rnd_idle, output int exp_len, output int exp_beats, output bit exp_to);
    int   g;
    bit   fin;
    drv_t d;
    plan.delete();
    exp_len = 0; exp_beats = 0; exp_to = 1'b0; fin = 1'b0;
    for (int b = 1; b <= nbeats && !fin; b++) begin
      g = (b == 1 && pre_idle >= 0) ? pre_idle : (rnd_idle ? int'($urandom_range(0, 2)) : 0);
      if (g >= TIMEOUT) begin
        exp_len += TIMEOUT;
        exp_to = 1'b1;
        fin = 1'b1;
      end else begin
        for (int k = 0; k < g; k++) begin
          d.v = 1'($urandom_range(0, 1));
          d.r = d.v ? 1'b0 : 1'($urandom_range(0, 1));
          d.l = 1'($urandom_range(0, 1));
          plan.push_back(d);
        end
        d.v = 1'b1; d.r = 1'b1; d.l = !tmo && (b == nbeats);
        plan.push_back(d);
        exp_len += g + 1;
        exp_beats = b;
        if ((!tmo && b == nbeats) || (sz != 0 && b == int'(sz))) fin = 1'b1;
      end
    end
    if (!fin) begin
      exp_len += TIMEOUT;
      exp_to = 1'b1;
    end
  endtask

  task automatic drive_channel(output int hi);
    hi = 0;
    while (en === 1'b1 && hi < 20000) begin
      if (hi < plan.size()) {probe_tvalid, probe_tready, probe_tlast} = plan[hi];
      else idle_drive();
      hi++;
      @(negedge ap_clk);
    end
    idle_drive();
  endtask

  task automatic wait_en(output int low);
    low = 0;
    while (en !== 1'b1 && low < 100) begin
      low++;
      @(negedge ap_clk);
    end
    chk("en_rise", en, 1);
  endtask

  task automatic wait_done(output int w);
    w = 0;
    while (done !== 1'b1 && w < 100) begin
      @(negedge ap_clk);
      w++;
    end
    chk("done_pulse", done, 1);
  endtask

  // mode: 0 = tlast on beat nbeats, 1 = stall after nbeats beats, 2 = random per channel
  task automatic sweep(input logic [7:0] mask, input logic [16:0] sz, input int nbeats, input int mode,
                       input int pre_idle, input bit rnd_idle);
    logic [7:0] exp_done, exp_tmo;
    int low, hi, len, nb, w, n;
    bit to, tm, first;
    exp_done = '0; exp_tmo = '0; first = 1'b1;
    start = 1'b1; chan_mask = mask; size_cfg = sz;
    @(negedge ap_clk);
    start = 1'b0; chan_mask = 8'($urandom); size_cfg = 17'($urandom);
    chk("busy_after_start", busy, 1);
    if (mask == 8'h00) begin
      chk("empty_done", done, 1);
      chk("empty_en", en, 0);
      @(negedge ap_clk);
      chk("empty_done_end", done, 0);
      chk("empty_busy_end", busy, 0);
      chk("empty_chan_done", chan_done, 0);
      chk("empty_chan_tmo", chan_tmo, 0);
    end else begin
      for (int c = 0; c < 8; c++) begin
        if (mask[c]) begin
          wait_en(low);
          chk("arm_gap_len", low, first ? 1 : GAP + 1);
          first = 1'b0;
          chk("sel", sel, c);
          chk("size", size, sz);
          n = nbeats;
          tm = (mode == 1);
          if (mode == 2) begin
            tm = ($urandom_range(0, 7) == 0);
            n  = tm ? int'($urandom_range(0, 3)) : int'($urandom_range(1, 12));
          end
          build_plan(n, tm, sz, pre_idle, rnd_idle, len, nb, to);
          drive_channel(hi);
          chk("en_high_len", hi, len);
          if (to) exp_tmo[c] = 1'b1;
          else    exp_done[c] = 1'b1;
          chk("beat_cnt", beat_cnt, STATS ? nb : 0);
          chk("chan_done_run", chan_done, exp_done);
          chk("chan_tmo_run", chan_tmo, exp_tmo);
        end
      end
      wait_done(w);
      chk("fin_gap", w, GAP);
      chk("fin_busy", busy, 1);
      chk("fin_chan_done", chan_done, exp_done);
      chk("fin_chan_tmo", chan_tmo, exp_tmo);
      @(negedge ap_clk);
      chk("done_one_cycle", done, 0);
      chk("busy_cleared", busy, 0);
    end
  endtask

  initial begin
    int low, hi, len, nb;
    bit to, seen_done, seen_busy, seen_en;

    repeat (3) @(negedge ap_clk);
    check_all_zero("reset");
    ap_rst = 1'b0;
    @(negedge ap_clk);

    sweep(8'h05, 17'd16, 16, 0, 0, 1'b0);
    sweep(8'h02, 17'd100, 10, 0, -1, 1'b1);
    sweep(8'h80, 17'd0, 0, 1, -1, 1'b0);
    sweep(8'h00, 17'd5, 1, 0, -1, 1'b0);
    sweep(8'h10, 17'd5, 5, 0, -1, 1'b1);
    sweep(8'h08, 17'd7, 20, 0, -1, 1'b1);
    sweep(8'h01, 17'd0, 1, 0, TIMEOUT - 1, 1'b0);
    sweep(8'h40, 17'd0, 1, 0, TIMEOUT, 1'b0);

    // abort during the second channel, on a cycle that would also end the capture
    start = 1'b1; chan_mask = 8'h0F; size_cfg = 17'd0;
    @(negedge ap_clk);
    start = 1'b0;
    wait_en(low);
    chk("abort_sel0", sel, 0);
    build_plan(3, 1'b0, 17'd0, -1, 1'b1, len, nb, to);
    drive_channel(hi);
    chk("abort_ch0_len", hi, len);
    wait_en(low);
    chk("abort_sel1", sel, 1);
    {probe_tvalid, probe_tready, probe_tlast} = 3'b110;
    repeat (2) @(negedge ap_clk);
    {probe_tvalid, probe_tready, probe_tlast} = 3'b111;
    abort = 1'b1; start = 1'b1; chan_mask = 8'hFF;
    @(negedge ap_clk);
    abort = 1'b0; start = 1'b0;
    idle_drive();
    chk("abort_en", en, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_chan_done", chan_done, 8'h01);
    chk("abort_chan_tmo", chan_tmo, 8'h00);
    chk("abort_beat_cnt", beat_cnt, STATS ? nb : 0);
    seen_done = 1'b0; seen_busy = 1'b0;
    repeat (8) begin
      @(negedge ap_clk);
      seen_done |= done;
      seen_busy |= busy;
    end
    chk("abort_no_done", seen_done, 0);
    chk("abort_stays_idle", seen_busy, 0);

    // start while busy is ignored; reset mid-capture does not resume
    start = 1'b1; chan_mask = 8'h03; size_cfg = 17'd9;
    @(negedge ap_clk);
    start = 1'b0;
    wait_en(low);
    build_plan(2, 1'b0, 17'd9, -1, 1'b0, len, nb, to);
    drive_channel(hi);
    chk("rst_ch0_len", hi, len);
    start = 1'b1; chan_mask = 8'hF0; size_cfg = 17'd77;
    @(negedge ap_clk);
    start = 1'b0;
    wait_en(low);
    chk("busy_start_gap", low, GAP);
    chk("busy_start_sel", sel, 1);
    chk("busy_start_size", size, 9);
    chk("busy_start_chan_done", chan_done, 8'h01);
    repeat (5) @(negedge ap_clk);
    ap_rst = 1'b1;
    #1;
    check_all_zero("mid_rst");
    @(negedge ap_clk);
    ap_rst = 1'b0;
    seen_en = 1'b0; seen_busy = 1'b0; seen_done = 1'b0;
    repeat (10) begin
      @(negedge ap_clk);
      seen_en |= en;
      seen_busy |= busy;
      seen_done |= done;
    end
    chk("post_rst_en", seen_en, 0);
    chk("post_rst_busy", seen_busy, 0);
    chk("post_rst_done", seen_done, 0);

    for (int s = 0; s < 8; s++) begin
      sweep(8'($urandom), 17'($urandom_range(0, 15)), 1, 2, -1, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
